ahb_ram_arbiter: RTL and testbench
==================================

// Module: ahb_ram_arbiter
// PURPOSE
//  Two-master AHB-Lite arbiter that shares the single-cycle RAM slave between the Cortex-M0 (M0) and a second master (M1, DMA/display refresh).
//  Sits between the per-master address decoders and the RAM slave port.
//  Zero added latency when uncontended. A master that loses arbitration has its address phase held and is stalled with HREADYOUT=0.
// PARAMETERS
//  MAX_WAIT  4  cycles M1 may lose consecutively before it overrides M0 (fixed-priority mode only); range 1..15
// PORTS
//  HCLK          in   1   system clock
//  HRESET        in   1   synchronous, active-high reset
//  Mx_HSEL       in   1   slave select from master x decoder (x=0,1)
//  Mx_HREADY     in   1   master x bus ready
//  Mx_HADDR      in   32  master x address
//  Mx_HTRANS     in   2   master x transfer type
//  Mx_HWRITE     in   1   master x write
//  Mx_HSIZE      in   3   master x size
//  Mx_HWDATA     in   32  master x write data
//  Mx_HREADYOUT  out  1   ready to master x
//  Mx_HRDATA     out  32  read data to master x (= S_HRDATA, broadcast)
//  S_HSEL, S_HADDR[32], S_HTRANS[2], S_HWRITE, S_HSIZE[3], S_HWDATA[32], S_HREADY  out  to RAM slave
//  S_HREADYOUT   in   1   RAM ready
//  S_HRDATA      in   32  RAM read data
// BEHAVIOUR
//  - Request: live_x = Mx_HSEL & Mx_HREADY & (Mx_HTRANS != IDLE). cand_x = pend_x ? hold_x : live_x.
//  - S_HREADY = (owner==NONE) | S_HREADYOUT. Arbitration happens only when S_HREADY=1; otherwise every candidate loses.
//  - Winner's address phase is driven combinationally on S_*, with S_HSEL=1 and S_HTRANS=NONSEQ (SEQ is converted, because interleaving breaks bursts).
//    With no winner: S_HSEL=0, S_HTRANS=IDLE.
//  - Winner gets owner<=x at the clock edge. A losing live request is captured: hold_x<={HADDR,HWRITE,HSIZE}, pend_x<=1.
//    pend_x clears on that master's grant.
//  - Data phase: S_HWDATA = owner's Mx_HWDATA. owner<=NONE at the edge when S_HREADYOUT=1 and no new grant is made.
//  - Mx_HREADYOUT = 0 if pend_x; else S_HREADYOUT if owner==x; else 1. This gives zero-wait forwarding when uncontended.
//  - Priority (default): M0 wins ties.
//    wait_cnt increments on each cycle M1 is a candidate and loses, and clears on M1 grant.
//    When wait_cnt==MAX_WAIT, M1 beats a live or pending M0.
//  - A pending candidate competes equally with a live candidate. A master cannot issue while pending, because its HREADY is low.
//  - Reset (HRESET sampled high at HCLK edge): pend_x=0, hold_x=0, owner=NONE, wait_cnt=0, rr_last=M1.
//    Outputs follow: Mx_HREADYOUT=1, S_HSEL=0, S_HTRANS=IDLE.
//    A pending or in-flight transfer is discarded on reset mid-operation.
//  - HRESP is not generated; the RAM is always OKAY.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: ties go to the master not granted last (rr_last updated on every grant). wait_cnt and MAX_WAIT are unused.
//  Not defined: fixed M0 priority with the MAX_WAIT starvation override.
// STRUCTURE
//  Package ahb_arb_pkg:
//    htrans_t enum {IDLE, BUSY, NONSEQ, SEQ}
//    owner_t enum {OWN_NONE, OWN_M0, OWN_M1}
//    addr_phase_t struct {haddr, hwrite, hsize}
//  Sub-module ahb_arb_hold, instantiated per master: live detect, hold register, pend flag, HREADYOUT generation.
//  The top level holds owner, the arbiter, wait_cnt/rr_last, and the S_* muxes.
// TESTING
//  1. M0 alone: write 0xDEADBEEF to 0x20, then read 0x20 -> S_HTRANS=NONSEQ in the same cycle, M0_HREADYOUT stays 1, read returns 0xDEADBEEF.
//  2. Same cycle t: M0 read 0x10 and M1 write 0x14 -> M0 forwarded at t.
//     M1_HREADYOUT=0 at t+1 while S_HADDR=0x14 is forwarded; M1 completes at t+2.
//  3. Fixed priority, MAX_WAIT=4: M0 issues back-to-back, M1 pending -> M1 granted on its 5th candidate cycle; wait_cnt returns to 0.
//  4. S_HREADYOUT=0 for 2 cycles in an M0 data phase while M1 requests -> S_HTRANS=IDLE, no grant; M1 is forwarded the cycle S_HREADYOUT=1.
//  5. HRESET=1 while M1 is pending -> after the edge: M1_HREADYOUT=1, S_HSEL=0, owner=NONE, no RAM access issued.
//  6. ARB_ROUND_ROBIN_EN: both masters request every cycle for 4 grants -> grant order M0, M1, M0, M1.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared types for the two-master AHB-Lite RAM arbiter.
// The optional round-robin tie-break is enabled with ARB_ROUND_ROBIN_EN.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  typedef struct packed {
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
  } addr_phase_t;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/ahb_arb_hold.sv
// Per-master front end: request detection, held address phase for a losing
// request, pending flag and the HREADYOUT returned to that master.
module ahb_arb_hold
  import ahb_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic        hready,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic        grant,
  input  logic        own,
  input  logic        s_hreadyout,
  output logic        cand,
  output addr_phase_t cand_phase,
  output logic        pend,
  output logic        hreadyout
);

  logic        live;
  addr_phase_t live_phase;
  addr_phase_t hold;

  assign live       = hsel & hready & (htrans != IDLE);
  assign live_phase = '{haddr: haddr, hwrite: hwrite, hsize: hsize};
  assign cand       = pend | live;
  assign cand_phase = pend ? hold : live_phase;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      hold <= '0;
    end else if (grant) begin
      pend <= 1'b0;
    end else if (live && !pend) begin
      pend <= 1'b1;
      hold <= live_phase;
    end
  end

  // A pending master is stalled until its held transfer is granted and completes.
  always_comb begin
    hreadyout = 1'b1;
    if (pend)
      hreadyout = 1'b0;
    else if (own)
      hreadyout = s_hreadyout;
  end

endmodule

// File: rtl/ahb_ram_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single-cycle RAM slave.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed M0 priority with starvation override.
module ahb_ram_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        M0_HSEL,
  input  logic        M0_HREADY,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADYOUT,
  output logic [31:0] M0_HRDATA,
  input  logic        M1_HSEL,
  input  logic        M1_HREADY,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADYOUT,
  output logic [31:0] M1_HRDATA,
  output logic        S_HSEL,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  output logic        S_HREADY,
  input  logic        S_HREADYOUT,
  input  logic [31:0] S_HRDATA
);

  owner_t      owner;
  owner_t      owner_next;
  logic        cand0, cand1;
  logic        pend0, pend1;
  logic        grant0, grant1;
  logic        s_hready;
  logic        m1_priority;
  addr_phase_t phase0, phase1;
  addr_phase_t win_phase;

  ahb_arb_hold u_hold0 (
    .clk         (HCLK),
    .rst         (HRESET),
    .hsel        (M0_HSEL),
    .hready      (M0_HREADY),
    .htrans      (M0_HTRANS),
    .haddr       (M0_HADDR),
    .hwrite      (M0_HWRITE),
    .hsize       (M0_HSIZE),
    .grant       (grant0),
    .own         (owner == OWN_M0),
    .s_hreadyout (S_HREADYOUT),
    .cand        (cand0),
    .cand_phase  (phase0),
    .pend        (pend0),
    .hreadyout   (M0_HREADYOUT)
  );

  ahb_arb_hold u_hold1 (
    .clk         (HCLK),
    .rst         (HRESET),
    .hsel        (M1_HSEL),
    .hready      (M1_HREADY),
    .htrans      (M1_HTRANS),
    .haddr       (M1_HADDR),
    .hwrite      (M1_HWRITE),
    .hsize       (M1_HSIZE),
    .grant       (grant1),
    .own         (owner == OWN_M1),
    .s_hreadyout (S_HREADYOUT),
    .cand        (cand1),
    .cand_phase  (phase1),
    .pend        (pend1),
    .hreadyout   (M1_HREADYOUT)
  );

  // The bus is free for a new address phase when idle or the current data phase ends.
  assign s_hready  = (owner == OWN_NONE) | S_HREADYOUT;
  assign S_HREADY  = s_hready;
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last;

  always_ff @(posedge HCLK) begin
    if (HRESET)
      rr_last <= 1'b1;
    else if (grant0)
      rr_last <= 1'b0;
    else if (grant1)
      rr_last <= 1'b1;
  end

  assign m1_priority = ~rr_last;
`else
  logic [WAIT_W-1:0] wait_cnt;

  // Saturates at MAX_WAIT so a long slave stall cannot wrap the counter.
  always_ff @(posedge HCLK) begin
    if (HRESET)
      wait_cnt <= '0;
    else if (grant1)
      wait_cnt <= '0;
    else if (cand1 && (wait_cnt != WAIT_W'(MAX_WAIT)))
      wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  assign m1_priority = (wait_cnt == WAIT_W'(MAX_WAIT));
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET)
      owner <= OWN_NONE;
    else
      owner <= owner_next;
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (s_hready) begin
      if (cand1 && (!cand0 || m1_priority))
        grant1 = 1'b1;
      else if (cand0)
        grant0 = 1'b1;
    end

    owner_next = owner;
    if (grant0)
      owner_next = OWN_M0;
    else if (grant1)
      owner_next = OWN_M1;
    else if (S_HREADYOUT)
      owner_next = OWN_NONE;
  end

  // NOTE: every combinational output is given a default first so no latch is inferred.
  always_comb begin
    win_phase = '0;
    S_HSEL    = 1'b0;
    S_HTRANS  = IDLE;
    if (grant0) begin
      win_phase = phase0;
      S_HSEL    = 1'b1;
      S_HTRANS  = NONSEQ;
    end else if (grant1) begin
      win_phase = phase1;
      S_HSEL    = 1'b1;
      S_HTRANS  = NONSEQ;
    end
    S_HADDR  = win_phase.haddr;
    S_HWRITE = win_phase.hwrite;
    S_HSIZE  = win_phase.hsize;

    // Interleaving masters breaks bursts, so every granted beat is issued as NONSEQ.
    case (owner)
      OWN_M0:  S_HWDATA = M0_HWDATA;
      OWN_M1:  S_HWDATA = M1_HWDATA;
      default: S_HWDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Directed bench for ahb_ram_arbiter: expected RAM-side address phases are queued
// by the stimulus and popped by a monitor as they appear on the slave port.
module tb_ahb_ram_arbiter;
  import ahb_arb_pkg::*;

  logic        HCLK;
  logic        HRESET;
  logic        M0_HSEL, M0_HREADY, M0_HWRITE, M0_HREADYOUT;
  logic [31:0] M0_HADDR, M0_HWDATA, M0_HRDATA;
  logic [1:0]  M0_HTRANS;
  logic [2:0]  M0_HSIZE;
  logic        M1_HSEL, M1_HREADY, M1_HWRITE, M1_HREADYOUT;
  logic [31:0] M1_HADDR, M1_HWDATA, M1_HRDATA;
  logic [1:0]  M1_HTRANS;
  logic [2:0]  M1_HSIZE;
  logic        S_HSEL, S_HWRITE, S_HREADY, S_HREADYOUT;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HSIZE;

  typedef struct {
    logic [31:0] haddr;
    logic        hwrite;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic  mon_en   = 1'b0;
  logic  ram_ready;

  ahb_ram_arbiter #(.MAX_WAIT(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HSEL(M0_HSEL), .M0_HREADY(M0_HREADY), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS),
    .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE), .M0_HWDATA(M0_HWDATA),
    .M0_HREADYOUT(M0_HREADYOUT), .M0_HRDATA(M0_HRDATA),
    .M1_HSEL(M1_HSEL), .M1_HREADY(M1_HREADY), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS),
    .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE), .M1_HWDATA(M1_HWDATA),
    .M1_HREADYOUT(M1_HREADYOUT), .M1_HRDATA(M1_HRDATA),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
    .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
    .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Single-master bus per side: a master's HREADY is what the arbiter returns to it.
  assign M0_HREADY = M0_HREADYOUT;
  assign M1_HREADY = M1_HREADYOUT;

  // Behavioural single-cycle RAM slave with a bench-controlled ready.
  logic [31:0] mem [0:63];
  logic        dp_act, dp_write;
  logic [5:0]  dp_idx;

  initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_act <= 1'b0;
    end else begin
      if (dp_act && ram_ready && dp_write) mem[dp_idx] <= S_HWDATA;
      if (S_HREADY) begin
        dp_act   <= S_HSEL && (S_HTRANS == NONSEQ);
        dp_write <= S_HWRITE;
        dp_idx   <= S_HADDR[7:2];
      end
    end
  end

  assign S_HREADYOUT = ram_ready;
  assign S_HRDATA    = dp_act ? mem[dp_idx] : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every address phase presented to the RAM must match the next queued one.
  always @(negedge HCLK) begin
    if (mon_en && S_HSEL) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: RAM access to 0x%08h, none expected", S_HADDR);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        check("sb_haddr", S_HADDR, e.haddr);
        check("sb_hwrite", 32'(S_HWRITE), 32'(e.hwrite));
        check("sb_htrans", 32'(S_HTRANS), 32'(NONSEQ));
        check("sb_hsize", 32'(S_HSIZE), 32'd2);
      end
    end
  end

  task automatic expect_xfer(input logic [31:0] a, input logic w);
    exp_q.push_back('{haddr: a, hwrite: w});
  endtask

  task automatic m_issue(input int m, input logic [31:0] a, input logic w);
    if (m == 0) begin
      M0_HSEL = 1'b1; M0_HTRANS = NONSEQ; M0_HADDR = a; M0_HWRITE = w; M0_HSIZE = 3'd2;
    end else begin
      M1_HSEL = 1'b1; M1_HTRANS = NONSEQ; M1_HADDR = a; M1_HWRITE = w; M1_HSIZE = 3'd2;
    end
  endtask

  task automatic m_idle(input int m);
    if (m == 0) begin
      M0_HSEL = 1'b0; M0_HTRANS = IDLE;
    end else begin
      M1_HSEL = 1'b0; M1_HTRANS = IDLE;
    end
  endtask

  task automatic settle();
    @(negedge HCLK);
  endtask

  task automatic next();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1;
    ram_ready = 1'b1;
    m_idle(0); m_idle(1);
    M0_HADDR = '0; M0_HWRITE = 1'b0; M0_HSIZE = 3'd2; M0_HWDATA = '0;
    M1_HADDR = '0; M1_HWRITE = 1'b0; M1_HSIZE = 3'd2; M1_HWDATA = '0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    mon_en = 1'b1;

    settle();
    check("rst_m0_hreadyout", 32'(M0_HREADYOUT), 32'd1);
    check("rst_m1_hreadyout", 32'(M1_HREADYOUT), 32'd1);
    check("rst_s_hsel", 32'(S_HSEL), 32'd0);
    check("rst_s_htrans", 32'(S_HTRANS), 32'(IDLE));
    check("rst_owner", 32'(dut.owner), 32'(OWN_NONE));
    next();

    // 1: M0 alone, write then read back with zero added latency
    m_issue(0, 32'h20, 1'b1); expect_xfer(32'h20, 1'b1);
    settle();
    check("t1_wr_htrans", 32'(S_HTRANS), 32'(NONSEQ));
    check("t1_wr_hready", 32'(M0_HREADYOUT), 32'd1);
    next();
    M0_HWDATA = 32'hDEADBEEF;
    m_issue(0, 32'h20, 1'b0); expect_xfer(32'h20, 1'b0);
    settle();
    check("t1_hwdata", S_HWDATA, 32'hDEADBEEF);
    check("t1_rd_htrans", 32'(S_HTRANS), 32'(NONSEQ));
    check("t1_rd_hready", 32'(M0_HREADYOUT), 32'd1);
    next();
    m_idle(0);
    settle();
    check("t1_rdata", M0_HRDATA, 32'hDEADBEEF);
    check("t1_rd_done", 32'(M0_HREADYOUT), 32'd1);
    next();

    // 2: simultaneous requests, M0 first, M1 held one cycle
    m_issue(0, 32'h10, 1'b0); m_issue(1, 32'h14, 1'b1); expect_xfer(32'h10, 1'b0);
    settle();
    check("t2_m0_fwd", S_HADDR, 32'h10);
    check("t2_m1_accept", 32'(M1_HREADYOUT), 32'd1);
    next();
    m_idle(0); m_idle(1); M1_HWDATA = 32'hCAFEF00D; expect_xfer(32'h14, 1'b1);
    settle();
    check("t2_m1_stall", 32'(M1_HREADYOUT), 32'd0);
    check("t2_held_haddr", S_HADDR, 32'h14);
    next();
    settle();
    check("t2_m1_done", 32'(M1_HREADYOUT), 32'd1);
    check("t2_hwdata", S_HWDATA, 32'hCAFEF00D);
    next();
    m_issue(0, 32'h14, 1'b0); expect_xfer(32'h14, 1'b0);
    next();
    m_idle(0);
    settle();
    check("t2_readback", M0_HRDATA, 32'hCAFEF00D);
    next();

`ifndef ARB_ROUND_ROBIN_EN
    // 3: M0 back-to-back starves M1 until wait_cnt reaches MAX_WAIT
    m_issue(1, 32'h40, 1'b1);
    for (int k = 0; k < 5; k++) begin
      m_issue(0, 32'h100 + 32'(4 * k), 1'b0);
      if (k == 1) begin
        m_idle(1);
        M1_HWDATA = 32'h5555AAAA;
      end
      if (k < 4) expect_xfer(32'h100 + 32'(4 * k), 1'b0);
      else       expect_xfer(32'h40, 1'b1);
      settle();
      check("t3_wait_cnt", 32'(dut.wait_cnt), 32'(k));
      if (k > 0 && k < 4) check("t3_m1_stall", 32'(M1_HREADYOUT), 32'd0);
      next();
    end
    m_idle(0); expect_xfer(32'h110, 1'b0);
    settle();
    check("t3_wait_clr", 32'(dut.wait_cnt), 32'd0);
    check("t3_m0_stall", 32'(M0_HREADYOUT), 32'd0);
    check("t3_m1_done", 32'(M1_HREADYOUT), 32'd1);
    check("t3_hwdata", S_HWDATA, 32'h5555AAAA);
    next();
    settle();
    check("t3_m0_done", 32'(M0_HREADYOUT), 32'd1);
    next();
`endif

    // 4: RAM wait states block arbitration; M1 goes the cycle the RAM is ready
    m_issue(0, 32'h30, 1'b1); expect_xfer(32'h30, 1'b1);
    next();
    m_idle(0); M0_HWDATA = 32'h12345678; ram_ready = 1'b0;
    m_issue(1, 32'h30, 1'b0);
    settle();
    check("t4_stall1_hsel", 32'(S_HSEL), 32'd0);
    check("t4_stall1_htrans", 32'(S_HTRANS), 32'(IDLE));
    check("t4_m0_wait", 32'(M0_HREADYOUT), 32'd0);
    next();
    m_idle(1);
    settle();
    check("t4_stall2_hsel", 32'(S_HSEL), 32'd0);
    check("t4_m1_pend", 32'(M1_HREADYOUT), 32'd0);
    next();
    ram_ready = 1'b1; expect_xfer(32'h30, 1'b0);
    settle();
    check("t4_m1_fwd", S_HADDR, 32'h30);
    check("t4_m0_done", 32'(M0_HREADYOUT), 32'd1);
    next();
    settle();
    check("t4_m1_done", 32'(M1_HREADYOUT), 32'd1);
    check("t4_rdata", M1_HRDATA, 32'h12345678);
    next();

    // 5: reset while M1 is pending discards it
    m_issue(0, 32'h50, 1'b0); m_issue(1, 32'h54, 1'b1); expect_xfer(32'h50, 1'b0);
    next();
    m_idle(0); m_idle(1); ram_ready = 1'b0; HRESET = 1'b1;
    settle();
    check("t5_pre_hsel", 32'(S_HSEL), 32'd0);
    check("t5_pre_pend", 32'(M1_HREADYOUT), 32'd0);
    next();
    HRESET = 1'b0; ram_ready = 1'b1;
    settle();
    check("t5_m1_hreadyout", 32'(M1_HREADYOUT), 32'd1);
    check("t5_m0_hreadyout", 32'(M0_HREADYOUT), 32'd1);
    check("t5_s_hsel", 32'(S_HSEL), 32'd0);
    check("t5_s_htrans", 32'(S_HTRANS), 32'(IDLE));
    check("t5_owner", 32'(dut.owner), 32'(OWN_NONE));
    next();
    settle();
    check("t5_no_access", 32'(S_HSEL), 32'd0);
    next();

`ifdef ARB_ROUND_ROBIN_EN
    // 6: both masters request continuously, grants alternate M0, M1, M0, M1
    begin
      int i0 = 0;
      int i1 = 0;
      expect_xfer(32'h200, 1'b0);
      expect_xfer(32'h300, 1'b0);
      expect_xfer(32'h204, 1'b0);
      expect_xfer(32'h304, 1'b0);
      expect_xfer(32'h208, 1'b0);
      for (int k = 0; k < 4; k++) begin
        m_issue(0, 32'h200 + 32'(4 * i0), 1'b0);
        m_issue(1, 32'h300 + 32'(4 * i1), 1'b0);
        settle();
        if (M0_HREADYOUT) i0++;
        if (M1_HREADYOUT) i1++;
        next();
      end
      m_idle(0); m_idle(1);
      next();
      next();
    end
`endif

    repeat (2) next();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
